// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the VRAM arbiter slice.
package vram_arb_pkg;

   localparam int unsigned VRAM_ADDR_W       = 19;
   localparam int unsigned VRAM_DATA_W       = 3;
   localparam int unsigned VRAM_FIFO_DEPTH   = 4;
   localparam int unsigned VRAM_STARVE_LIMIT = 16;

   // Memory operation issued in a cycle; also the arbiter's IDLE/READ/WRITE state.
   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// CPU pixel-write buffer: power-of-two circular FIFO, head entry visible on rdata.
module vram_wr_fifo #(
   parameter int unsigned WIDTH = 22,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win over buffered CPU writes,
// except when the head write has starved long enough to be forced through.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = VRAM_ADDR_W,
   parameter int unsigned DATA_W       = VRAM_DATA_W,
   parameter int unsigned FIFO_DEPTH   = VRAM_FIFO_DEPTH,
   parameter int unsigned STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          iWrValid,
   input  logic [ADDR_W-1:0]             iWrAddr,
   input  logic [DATA_W-1:0]             iWrData,
   output logic                          oWrReady,
   input  logic                          iRdValid,
   input  logic [ADDR_W-1:0]             iRdAddr,
   output logic                          oRdDataValid,
   output logic [DATA_W-1:0]             oRdData,
   output logic                          oRdMiss,
   output logic                          oMemWe,
   output logic [ADDR_W-1:0]             oMemAddr,
   output logic [DATA_W-1:0]             oMemDataIn,
   input  logic [DATA_W-1:0]             iMemDataOut,
   output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

   localparam int unsigned ENT_W = ADDR_W + DATA_W;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   logic [ENT_W-1:0]  head;
   logic              fifo_full, fifo_empty;
   logic              push, pop;
   logic              displaced;

   op_e               state_q, state_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic [1:0]        rd_pend_q, rd_pend_d;
   logic [1:0]        rd_drop_q, rd_drop_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_miss_q, rd_miss_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   assign push     = iWrValid && !fifo_full && !Reset;
   assign pop      = (state_d == OP_WRITE) && !Reset;
   assign oWrReady = !fifo_full;

   vram_wr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk   (Clock),
      .rst   (Reset),
      .push  (push),
      .wdata ({iWrAddr, iWrData}),
      .pop   (pop),
      .rdata (head),
      .count (oFifoCount),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Arbitration, starvation tracking and the two-stage read-return pipe.
   always_comb begin
      state_d    = OP_NONE;
      starve_d   = starve_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      displaced  = 1'b0;

      if (!fifo_empty && (starve_q == STV_W'(STARVE_LIMIT))) begin
         state_d   = OP_WRITE;
         displaced = iRdValid;
      end else if (iRdValid) begin
         state_d = OP_READ;
         if (!fifo_empty) begin
            starve_d = starve_q + STV_W'(1);
         end
      end else if (!fifo_empty) begin
         state_d = OP_WRITE;
      end

      if (state_d == OP_WRITE) begin
         starve_d                = '0;
         {mem_addr_d, mem_din_d} = head;
      end else if (state_d == OP_READ) begin
         mem_addr_d = iRdAddr;
      end

      // Every sampled read returns two cycles later, as data or as a miss.
      rd_pend_d  = {rd_pend_q[0], iRdValid};
      rd_drop_d  = {rd_drop_q[0], displaced};
      rd_valid_d = rd_pend_q[1];
      rd_miss_d  = rd_drop_q[1];
      rd_data_d  = (rd_pend_q[1] && !rd_drop_q[1]) ? iMemDataOut : '0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= OP_NONE;
         starve_q   <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         rd_pend_q  <= '0;
         rd_drop_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_miss_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rd_pend_q  <= rd_pend_d;
         rd_drop_q  <= rd_drop_d;
         rd_valid_q <= rd_valid_d;
         rd_miss_q  <= rd_miss_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign oMemWe       = (state_q == OP_WRITE);
   assign oMemAddr     = mem_addr_q;
   assign oMemDataIn   = mem_din_q;
   assign oRdDataValid = rd_valid_q;
   assign oRdMiss      = rd_miss_q;
   assign oRdData      = rd_data_q;

endmodule
